// File: rtl/nmix_inv.sv
// nmix_inv: bit-serial inverse of the nmix nonlinear mixer, recovers X from Y and key R, BPC bits per clock
module nmix_inv #(
  parameter int WIDTH = 32,
  parameter int BPC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] X,
  output logic             busy,
  output logic             done
);
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - BPC);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] ys, rs;
  logic [IW-1:0] idx;
  logic carry, cn;
  logic [BPC-1:0] yg, rg, grp;
  assign yg = BPC'(ys >> idx);
  assign rg = BPC'(rs >> idx);
  // carry ripples through the group within a cycle and is registered between groups
  always_comb begin
    cn = carry;
    grp = '0;
    for (int b = 0; b < BPC; b++) begin
      grp[b] = yg[b] ^ rg[b] ^ cn;
      cn = cn ^ (grp[b] & rg[b]);
    end
  end
  always_comb begin
    nxt = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (idx == LAST ? DONE : RUN) : IDLE;
    busy = state == RUN;
    done = state == DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ys <= '0;
      rs <= '0;
      X <= '0;
      carry <= 1'b0;
      idx <= '0;
    end else if (state == IDLE && start) begin
      ys <= Y;
      rs <= R;
      X <= '0;
      carry <= 1'b0;
      idx <= '0;
    end else if (state == RUN) begin
      X <= X | (WIDTH'(grp) << idx);
      carry <= cn;
      idx <= idx == LAST ? '0 : idx + IW'(BPC);
    end
endmodule

// File: tb/tb_nmix_inv.sv
// tb_nmix_inv: checks nmix_inv for BPC=1, 4 and 32 side by side against a forward-mixer round-trip model
module tb_nmix_inv;
  logic clk = 0, reset = 0, start = 0;
  logic [31:0] Y = 0, R = 0;
  logic [31:0] xs[3];
  logic dn[3], bs[3];
  int tests = 0, fails = 0;
  int lat[3], cnt[3];
  logic [31:0] xv[3], xe[3];
  logic bsy[3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    nmix_inv #(.WIDTH(32), .BPC(g == 0 ? 1 : g == 1 ? 4 : 32)) u (
      .clk(clk), .reset(reset), .start(start), .Y(Y), .R(R),
      .X(xs[g]), .busy(bs[g]), .done(dn[g]));
  end
  function automatic int bpc(input int d);
    return d == 0 ? 1 : d == 1 ? 4 : 32;
  endfunction
  function automatic logic [31:0] fwd(input logic [31:0] x, input logic [31:0] r);
    logic c = 0;
    logic [31:0] y;
    for (int i = 0; i < 32; i++) begin
      y[i] = x[i] ^ r[i] ^ c;
      c = c ^ (x[i] & r[i]);
    end
    return y;
  endfunction
  task automatic run_op(input logic [31:0] y, input logic [31:0] r, input bit abuse,
                        input logic [31:0] ay, input logic [31:0] ar);
    @(negedge clk);
    Y = y; R = r; start = 1;
    @(negedge clk);
    start = 0;
    for (int d = 0; d < 3; d++) begin lat[d] = -1; cnt[d] = 0; xv[d] = 'x; bsy[d] = 1'bx; end
    for (int c = 1; c <= 36; c++) begin
      if (abuse && c == 2) begin Y = ay; R = ar; end
      start = abuse && c == 5;
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        if (dn[d]) begin
          cnt[d]++;
          if (lat[d] < 0) begin lat[d] = c; xv[d] = xs[d]; bsy[d] = bs[d]; end
        end
    end
    start = 0;
    for (int d = 0; d < 3; d++) xe[d] = xs[d];
  endtask
  task automatic test_reset;
    #1 reset = 1;
    #1;
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (xs[d] !== 0 || bs[d] !== 0 || dn[d] !== 0) begin
        fails++; $display("FAIL reset_state bpc=%0d got X=%h busy=%b done=%b want 0/0/0", bpc(d), xs[d], bs[d], dn[d]);
      end
    end
    repeat (2) @(negedge clk);
    reset = 0;
    run_op(32'h12345678, 32'h0F0F0F0F, 0, 0, 0);
    @(negedge clk);
    #2 reset = 1;
    #1;
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (xs[d] !== 0 || bs[d] !== 0 || dn[d] !== 0) begin
        fails++; $display("FAIL async_reset bpc=%0d got X=%h busy=%b done=%b want 0/0/0", bpc(d), xs[d], bs[d], dn[d]);
      end
    end
    @(negedge clk);
    reset = 0;
  endtask
  task automatic test_known(input logic [31:0] y, input logic [31:0] r, input logic [31:0] x);
    run_op(y, r, 0, 0, 0);
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (xv[d] !== x) begin fails++; $display("FAIL known_x bpc=%0d Y=%h R=%h got %h want %h", bpc(d), y, r, xv[d], x); end
      tests++;
      if (lat[d] !== 32 / bpc(d) || cnt[d] !== 1) begin
        fails++; $display("FAIL known_timing bpc=%0d got lat=%0d pulses=%0d want lat=%0d pulses=1", bpc(d), lat[d], cnt[d], 32 / bpc(d));
      end
      tests++;
      if (bsy[d] !== 0 || xe[d] !== x) begin
        fails++; $display("FAIL known_hold bpc=%0d got busy_at_done=%b X_later=%h want 0 %h", bpc(d), bsy[d], xe[d], x);
      end
    end
  endtask
  task automatic test_round_trip;
    logic [31:0] x, r;
    int bad = 0;
    test_known(fwd(32'h8DDA6AD3, 32'd84765823), 32'd84765823, 32'h8DDA6AD3);
    for (int n = 0; n < 1000; n++) begin
      x = $urandom; r = $urandom;
      if (n < 4) r = n[0] ? 32'hFFFFFFFF : 32'h0;
      run_op(fwd(x, r), r, 0, 0, 0);
      for (int d = 0; d < 3; d++) begin
        tests++;
        if (xv[d] !== x || lat[d] !== 32 / bpc(d)) begin
          fails++; bad++;
          if (bad < 10) $display("FAIL round_trip bpc=%0d R=%h got X=%h lat=%0d want X=%h lat=%0d", bpc(d), r, xv[d], lat[d], x, 32 / bpc(d));
        end
      end
    end
  endtask
  task automatic test_abuse;
    logic [31:0] x = $urandom, r = $urandom;
    run_op(fwd(x, r), r, 1, $urandom, $urandom);
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (xv[d] !== x || lat[d] !== 32 / bpc(d)) begin
        fails++; $display("FAIL abuse bpc=%0d got X=%h lat=%0d want X=%h lat=%0d", bpc(d), xv[d], lat[d], x, 32 / bpc(d));
      end
    end
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (cnt[d] !== 1) begin fails++; $display("FAIL abuse_pulses bpc=%0d got %0d want 1", bpc(d), cnt[d]); end
    end
  endtask
  task automatic test_back_to_back;
    logic [31:0] x = $urandom, r = $urandom;
    int t[3][$];
    logic [31:0] got[3][$];
    @(negedge clk);
    Y = fwd(x, r); R = r; start = 1;
    for (int c = 0; c < 110; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) if (dn[d]) begin t[d].push_back(c); got[d].push_back(xs[d]); end
    end
    start = 0;
    repeat (40) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (t[d].size() < 3) begin
        fails++; $display("FAIL b2b_count bpc=%0d got %0d pulses want >=3", bpc(d), t[d].size());
      end else
        for (int k = 0; k < 2; k++) begin
          tests++;
          if (t[d][k+1] - t[d][k] !== 32 / bpc(d) + 2 || got[d][k+1] !== x) begin
            fails++; $display("FAIL b2b bpc=%0d got period=%0d X=%h want %0d %h", bpc(d), t[d][k+1] - t[d][k], got[d][k+1], 32 / bpc(d) + 2, x);
          end
        end
    end
  endtask
  task automatic test_reset_mid;
    logic [31:0] x = $urandom, r = $urandom;
    int pulses = 0;
    @(negedge clk);
    Y = fwd(x, r); R = r; start = 1;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    #2 reset = 1;
    #1;
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (xs[d] !== 0 || bs[d] !== 0 || dn[d] !== 0) begin
        fails++; $display("FAIL mid_reset bpc=%0d got X=%h busy=%b done=%b want 0/0/0", bpc(d), xs[d], bs[d], dn[d]);
      end
    end
    @(negedge clk);
    reset = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) pulses += int'(dn[d] === 1'b1);
    end
    tests++;
    if (pulses !== 0) begin fails++; $display("FAIL mid_reset_done got %0d pulses want 0", pulses); end
    test_known(fwd(x, r), r, x);
  endtask
  initial begin
    test_reset;
    test_known(32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF);
    test_known(32'h00000000, 32'hFFFFFFFF, 32'h00000001);
    test_known(32'h00000001, 32'h00000001, 32'h00000000);
    test_round_trip;
    test_abuse;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
